// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcodes, FSM states, flag layout
// and opcode classification helpers.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_WB
    } state_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // ADD..MUL write Rx back; CMP and the illegal range do not.
    function automatic logic op_writes(input logic [3:0] op);
        return op <= OP_MUL;
    endfunction

    function automatic logic op_sets_flags(input logic [3:0] op);
        return (op <= OP_SHR) || (op == OP_MUL) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/alu_exec_unit_seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per clock, LSB first.
// Bit 0 is folded into the load cycle, so done pulses DATA_W cycles after start.
module seq_multiplier #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [2*DATA_W-1:0] mcand;
    logic [DATA_W-1:0]   mplier;
    logic [CNT_W-1:0]    cnt;
    logic                running;

    // NOTE: every register here is assigned with <= so all flops update
    // together on the edge; blocking = would let later lines see new values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (start && !running) begin
                mcand   <= {{DATA_W{1'b0}}, a} << 1;
                mplier  <= b >> 1;
                product <= b[0] ? {{DATA_W{1'b0}}, a} : '0;
                cnt     <= CNT_W'(1);
                running <= 1'b1;
            end else if (running) begin
                if (mplier[0]) begin
                    product <= product + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute stage driving a register bank: fetch Rx/Ry, compute with a
// combinational ALU or the sequential multiplier, write back to Rx, keep {Z,N,C,V}.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_start,
    input  logic [3:0]        in_opcode,
    input  logic [SEL_W-1:0]  in_rx_sel,
    input  logic [SEL_W-1:0]  in_ry_sel,
    input  logic [DATA_W-1:0] in_rx_data,
    input  logic [DATA_W-1:0] in_ry_data,
    output logic [SEL_W-1:0]  out_rx_selector,
    output logic [SEL_W-1:0]  out_ry_selector,
    output logic [DATA_W-1:0] out_data,
    output logic              out_write_en,
    output logic              out_busy,
    output logic              out_done,
    output logic [3:0]        out_flags
);

    localparam int MSB = DATA_W - 1;

    state_t              state;
    logic [3:0]          opcode;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [DATA_W-1:0]   alu_res;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic                carry;
    logic                ovf;
    logic [3:0]          flags_cand;
    logic                mul_start;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;

    // The multiplier loads straight from the bank during FETCH so its result
    // is ready in time for write-back in cycle 10.
    assign mul_start = (state == ST_FETCH) && (opcode == OP_MUL);

    seq_multiplier #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (in_rx_data),
        .b       (in_ry_data),
        .done    (mul_done),
        .product (mul_product)
    );

    // NOTE: every output of this block gets a default before the case, so no
    // opcode path can leave a value unassigned and infer a latch.
    always_comb begin
        sum        = {1'b0, op_a} + {1'b0, op_b};
        diff       = {1'b0, op_a} - {1'b0, op_b};
        alu_res    = '0;
        carry      = 1'b0;
        ovf        = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res = sum[MSB:0];
                carry   = sum[DATA_W];
                ovf     = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = diff[MSB:0];
                carry   = diff[DATA_W];
                ovf     = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_SHL: begin
                alu_res = {op_a[MSB-1:0], 1'b0};
                carry   = op_a[MSB];
            end
            OP_SHR: begin
                alu_res = {1'b0, op_a[MSB:1]};
                carry   = op_a[0];
            end
            OP_MOV: alu_res = op_b;
            OP_MUL: begin
                alu_res = mul_product[MSB:0];
                carry   = |mul_product[2*DATA_W-1:DATA_W];
            end
            default: alu_res = '0;
        endcase

        flags_cand = out_flags;
        if (op_sets_flags(opcode)) begin
            flags_cand[FLAG_Z] = (alu_res == '0);
            flags_cand[FLAG_N] = alu_res[MSB];
            flags_cand[FLAG_C] = carry;
            flags_cand[FLAG_V] = ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            opcode          <= '0;
            op_a            <= '0;
            op_b            <= '0;
            out_rx_selector <= '0;
            out_ry_selector <= '0;
            out_data        <= '0;
            out_write_en    <= 1'b0;
            out_busy        <= 1'b0;
            out_done        <= 1'b0;
            out_flags       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_start) begin
                        opcode          <= in_opcode;
                        out_rx_selector <= in_rx_sel;
                        out_ry_selector <= in_ry_sel;
                        out_busy        <= 1'b1;
                        state           <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    op_a  <= in_rx_data;
                    op_b  <= in_ry_data;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (opcode != OP_MUL || mul_done) begin
                        out_data     <= alu_res;
                        out_write_en <= op_writes(opcode);
                        out_done     <= 1'b1;
                        state        <= ST_WB;
                    end
                end
                ST_WB: begin
                    out_write_en <= 1'b0;
                    out_done     <= 1'b0;
                    out_busy     <= 1'b0;
                    out_flags    <= flags_cand;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with a behavioural register bank attached to
// its selector/data/write ports.
module tb_alu_exec_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_start;
    logic [3:0] in_opcode;
    logic [2:0] in_rx_sel;
    logic [2:0] in_ry_sel;
    logic [7:0] in_rx_data;
    logic [7:0] in_ry_data;
    logic [2:0] out_rx_selector;
    logic [2:0] out_ry_selector;
    logic [7:0] out_data;
    logic       out_write_en;
    logic       out_busy;
    logic       out_done;
    logic [3:0] out_flags;

    logic [7:0] bank [8];
    logic       ld_en;
    logic [2:0] ld_sel;
    logic [7:0] ld_val;

    int vectors     = 0;
    int miscompares = 0;

    int         done_cycle;
    int         done_count;
    int         we_cycle;
    int         we_count;
    logic [7:0] wb_data;
    logic       busy_c1;
    logic       seen_activity;

    alu_exec_unit #(.DATA_W(8), .SEL_W(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_start        (in_start),
        .in_opcode       (in_opcode),
        .in_rx_sel       (in_rx_sel),
        .in_ry_sel       (in_ry_sel),
        .in_rx_data      (in_rx_data),
        .in_ry_data      (in_ry_data),
        .out_rx_selector (out_rx_selector),
        .out_ry_selector (out_ry_selector),
        .out_data        (out_data),
        .out_write_en    (out_write_en),
        .out_busy        (out_busy),
        .out_done        (out_done),
        .out_flags       (out_flags)
    );

    always #5 clk = ~clk;

    // Register bank: combinational reads, write on the rising edge.
    assign in_rx_data = bank[out_rx_selector];
    assign in_ry_data = bank[out_ry_selector];

    always @(posedge clk) begin
        if (out_write_en)
            bank[out_rx_selector] <= out_data;
        else if (ld_en)
            bank[ld_sel] <= ld_val;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic load(input logic [2:0] sel, input logic [7:0] val);
        ld_en  = 1'b1;
        ld_sel = sel;
        ld_val = val;
        @(posedge clk); #1;
        ld_en  = 1'b0;
    endtask

    // Issues one instruction and watches 14 cycles; cycle c is the one after edge c-1.
    task automatic run_op(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry,
                          input bit hold_start);
        in_opcode  = op;
        in_rx_sel  = rx;
        in_ry_sel  = ry;
        in_start   = 1'b1;
        done_cycle = -1;
        done_count = 0;
        we_cycle   = -1;
        we_count   = 0;
        wb_data    = '0;
        busy_c1    = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (!hold_start || c >= 4) in_start = 1'b0;
            if (c == 1) busy_c1 = out_busy;
            if (out_done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (out_write_en) begin
                we_count++;
                we_cycle = c;
                wb_data  = out_data;
            end
        end
        in_start = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_start  = 1'b0;
        in_opcode = '0;
        in_rx_sel = '0;
        in_ry_sel = '0;
        ld_en     = 1'b0;
        ld_sel    = '0;
        ld_val    = '0;
        #2;
        check("reset_outputs",
              {out_rx_selector, out_ry_selector, out_data, out_write_en, out_busy, out_done, out_flags},
              21'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ADD with signed overflow
        load(3'd1, 8'h7F);
        load(3'd2, 8'h01);
        run_op(4'd0, 3'd1, 3'd2, 1'b0);
        check("add_busy_c1", busy_c1, 1'b1);
        check("add_we_cycle", we_cycle, 3);
        check("add_we_count", we_count, 1);
        check("add_done_cycle", done_cycle, 3);
        check("add_done_count", done_count, 1);
        check("add_data", wb_data, 8'h80);
        check("add_bank_r1", bank[1], 8'h80);
        check("add_flags", out_flags, 4'b0101);
        check("add_busy_end", out_busy, 1'b0);

        // SUB to zero
        load(3'd3, 8'h05);
        load(3'd4, 8'h05);
        run_op(4'd1, 3'd3, 3'd4, 1'b0);
        check("sub_bank_r3", bank[3], 8'h00);
        check("sub_flags", out_flags, 4'b1000);

        // CMP: flags only, no write
        load(3'd1, 8'h10);
        load(3'd2, 8'h20);
        run_op(4'd9, 3'd1, 3'd2, 1'b0);
        check("cmp_we_count", we_count, 0);
        check("cmp_done_count", done_count, 1);
        check("cmp_bank_r1", bank[1], 8'h10);
        check("cmp_flags", out_flags, 4'b0110);

        // Illegal opcode: no write, flags held from CMP
        run_op(4'hF, 3'd1, 3'd2, 1'b0);
        check("ill_done_cycle", done_cycle, 3);
        check("ill_we_count", we_count, 0);
        check("ill_bank_r1", bank[1], 8'h10);
        check("ill_flags", out_flags, 4'b0110);

        // MUL with non-zero high byte
        load(3'd5, 8'h12);
        load(3'd6, 8'h10);
        run_op(4'd8, 3'd5, 3'd6, 1'b0);
        check("mul1_we_cycle", we_cycle, 10);
        check("mul1_done_cycle", done_cycle, 10);
        check("mul1_done_count", done_count, 1);
        check("mul1_bank_r5", bank[5], 8'h20);
        check("mul1_flags", out_flags, 4'b0010);

        // MUL fitting in the low byte
        load(3'd5, 8'h03);
        load(3'd6, 8'h04);
        run_op(4'd8, 3'd5, 3'd6, 1'b0);
        check("mul2_bank_r5", bank[5], 8'h0C);
        check("mul2_flags", out_flags, 4'b0000);

        // in_start held through the whole ADD, including the WB cycle
        load(3'd1, 8'h01);
        load(3'd2, 8'h02);
        run_op(4'd0, 3'd1, 3'd2, 1'b1);
        check("hold_done_count", done_count, 1);
        check("hold_we_count", we_count, 1);
        check("hold_bank_r1", bank[1], 8'h03);

        // Next start once IDLE is re-entered
        run_op(4'd0, 3'd1, 3'd2, 1'b0);
        check("b2b_done_cycle", done_cycle, 3);
        check("b2b_bank_r1", bank[1], 8'h05);

        // Shifts
        load(3'd0, 8'h81);
        run_op(4'd5, 3'd0, 3'd0, 1'b0);
        check("shl_bank_r0", bank[0], 8'h02);
        check("shl_flags", out_flags, 4'b0010);

        load(3'd0, 8'h01);
        run_op(4'd6, 3'd0, 3'd0, 1'b0);
        check("shr_bank_r0", bank[0], 8'h00);
        check("shr_flags", out_flags, 4'b1010);

        // MOV, then compare R0 with R7 to read the moved value back through ry
        load(3'd0, 8'h5A);
        run_op(4'd7, 3'd7, 3'd0, 1'b0);
        check("mov_bank_r7", bank[7], 8'h5A);
        run_op(4'd9, 3'd0, 3'd7, 1'b0);
        check("mov_cmp_we_count", we_count, 0);
        check("mov_cmp_flags", out_flags, 4'b1000);

        // Reset in cycle 5 of a MUL
        load(3'd5, 8'h12);
        load(3'd6, 8'h10);
        in_opcode = 4'd8;
        in_rx_sel = 3'd5;
        in_ry_sel = 3'd6;
        in_start  = 1'b1;
        @(posedge clk); #1;
        in_start  = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("midrst_busy_before", out_busy, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_outputs",
              {out_rx_selector, out_ry_selector, out_data, out_write_en, out_busy, out_done, out_flags},
              21'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen_activity = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_done || out_write_en || out_busy) seen_activity = 1'b1;
        end
        check("midrst_no_activity", seen_activity, 1'b0);
        check("midrst_bank_r5", bank[5], 8'h12);
        check("midrst_bank_r6", bank[6], 8'h10);

        // Normal operation resumes from IDLE
        load(3'd1, 8'h01);
        load(3'd2, 8'h01);
        run_op(4'd0, 3'd1, 3'd2, 1'b0);
        check("post_rst_done_cycle", done_cycle, 3);
        check("post_rst_bank_r1", bank[1], 8'h02);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
